// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// States, default width and the counter-width helper live here.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bit counter must hold 0..width-1; never narrower than one bit.
   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full-adder cell: purely combinational a + b + ci -> {co, s}.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic w_half;

   assign w_half = a ^ b;
   assign s      = w_half ^ ci;
   assign co     = (a & b) | (ci & w_half);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder cell.
// Build with SERIAL_ADDER_SUB_EN defined to add the 'sub' port (a - b via ~b + 1).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-2:0] r_s_sr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_fa_s;
   logic             w_fa_co;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;
   logic [WIDTH-1:0] w_s_next;

`ifdef SERIAL_ADDER_SUB_EN
   assign w_b_load = sub ? ~b_in : b_in;
   assign w_c_load = sub ? 1'b1  : cin;
`else
   assign w_b_load = b_in;
   assign w_c_load = cin;
`endif

   // The newest sum bit enters at the MSB; after WIDTH bits the word is aligned.
   assign w_s_next = {w_fa_s, r_s_sr};

   full_adder_cell u_fa (
      .a  (r_a_sr[0]),
      .b  (r_b_sr[0]),
      .ci (r_carry),
      .s  (w_fa_s),
      .co (w_fa_co)
   );

   // Control FSM, bit counter, operand/sum shift registers and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_s_sr  <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sr  <= a_in;
                  r_b_sr  <= w_b_load;
                  r_carry <= w_c_load;
                  r_cnt   <= '0;
                  r_state <= ST_SHIFT;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_s_sr  <= w_s_next[WIDTH-1:1];
               r_carry <= w_fa_co;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_sum   <= w_s_next;
                  r_cout  <= w_fa_co;
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_SHIFT;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (r_state == ST_SHIFT);
   assign done = (r_state == ST_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder; the sequential stage built around the team's 1-bit full-adder cell.
- Accepts two parallel operands plus carry-in on a start strobe.
- Feeds them LSB-first through one full-adder cell with a registered carry, one bit per clock.
- Presents the parallel sum and carry-out with a one-cycle done pulse to downstream logic.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous, active-low reset
- start  input   1      request; sampled only in IDLE
- a_in   input   WIDTH  operand A, captured on accepted start
- b_in   input   WIDTH  operand B, captured on accepted start
- cin    input   1      carry-in, captured on accepted start
- busy   output  1      high while in SHIFT
- done   output  1      one-cycle pulse, result valid
- sum    output  WIDTH  registered sum; holds last result
- cout   output  1      registered carry-out; holds last result

Behaviour:
- Interface clocking: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, shift registers/counter/carry cleared. Reset mid-operation aborts without producing a result.
- States: IDLE, SHIFT, DONE; encoding IDLE=0, SHIFT=1, DONE=2; value 3 -> IDLE.
- IDLE:
  - start=1 at edge E: a_sr<=a_in, b_sr<=b_in, carry<=cin, cnt<=0, state<=SHIFT.
  - start=0: remain IDLE.
- SHIFT, each edge:
  - full-adder cell inputs a_sr[0], b_sr[0], carry.
  - Sum bit shifts into MSB of s_sr (s_sr shifts right).
  - carry<=cell carry-out; a_sr/b_sr shift right; cnt<=cnt+1.
- Last SHIFT edge (cnt==WIDTH-1): also sum<=final s_sr value, cout<=final carry, state<=DONE.
- DONE: done=1 for exactly one cycle, then state<=IDLE unconditionally.
- Latency:
  - start accepted at edge E; bits processed on edges E+1..E+WIDTH.
  - done high in cycle after edge E+WIDTH.
  - Start held continuously gives an issue interval of WIDTH+2 cycles.
- busy=1 exactly in SHIFT (WIDTH cycles); done and busy never high together.
- start in SHIFT or DONE: ignored; no queuing; operands unaffected.
- a_in/b_in/cin changes after acceptance: no effect on the result in flight.
- Arithmetic: {cout,sum} = a_in + b_in + cin, unsigned, modulo 2^(WIDTH+1).
- sum/cout change only on the final SHIFT edge or reset; stable otherwise.
- busy, done, sum, cout are all flop-driven (decoded from state register allowed); no combinational input-to-output paths.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on accepted start.
  - sub=1: b_sr<=~b_in, carry<=1, cin ignored; sum = a_in - b_in mod 2^WIDTH.
  - cout=1 means no borrow (a_in >= b_in unsigned).
  - sub=0: identical to base behaviour.
- Undefined: no sub port; always adds.

Decomposition:
- Package serial_adder_pkg:
  - state typedef/localparams (IDLE, SHIFT, DONE).
  - CNT_W = $clog2(WIDTH) constant function/macro.
  - Default WIDTH constant.
- One sub-module: full_adder_cell (a, b, ci -> s, co), purely combinational, instantiated once.
- Control FSM, counter and shift registers stay in serial_adder.

Test Plan:
- Add, WIDTH=8: a=0x35, b=0x4A, cin=0 -> sum=0x7F, cout=0.
  - busy high 8 cycles; done single-cycle, exactly 8 edges after start edge.
- Carry: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Ignored start: start with a=0x10, b=0x01; pulse start with a=0xAA, b=0x55 at cycle 3 of SHIFT -> sum=0x11, cout=0, exactly one done.
- Mid-op reset: assert rst_n=0 during bit 4 -> immediately busy=0, done=0, sum=0x00, cout=0.
  - After release, a=0x01, b=0x02 -> sum=0x03.
- Back-to-back, start held high, 3 operand sets -> done pulses spaced exactly 10 cycles.
  - Plus exhaustive WIDTH=4 sweep (all a, b, cin) vs reference model.
- SERIAL_ADDER_SUB_EN:
  - a=0x20, b=0x10, sub=1 -> sum=0x10, cout=1.
  - a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0.
